// File: rtl/galvo_dac_spi.sv
// galvo_dac_spi: multi-channel galvo DAC SPI serializer with shared latch and laser blanking watchdog
module galvo_dac_spi #(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 12,
    parameter int SCLK_DIV      = 4,
    parameter int LATCH_W       = 2,
    parameter int BLANK_TIMEOUT = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] pt_data,
    input  logic [2:0]               pt_rgb,
    input  logic                     pt_valid,
    output logic                     pt_ready,
    output logic [2:0]               laser_rgb,
    output logic                     dac_sclk,
    output logic                     dac_mosi,
    output logic                     dac_csn,
    output logic                     dac_latchn,
    output logic                     busy
);
    localparam int WORD_W = DATA_W + 4;
    localparam int CW     = $clog2(SCLK_DIV > LATCH_W ? SCLK_DIV : LATCH_W) + 1;
    localparam int BITW   = $clog2(WORD_W);
    localparam int CHW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int BW     = BLANK_TIMEOUT > 0 ? $clog2(BLANK_TIMEOUT + 1) : 1;
    localparam bit WD_EN  = BLANK_TIMEOUT > 0;
    localparam logic [CW-1:0]   DIV_M1   = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0]   LAT_M1   = CW'(LATCH_W - 1);
    localparam logic [CHW-1:0]  LAST_CH  = CHW'(NUM_CH - 1);
    localparam logic [BITW-1:0] LAST_BIT = BITW'(WORD_W - 1);
    localparam logic [BW-1:0]   TMO      = BW'(BLANK_TIMEOUT);
    localparam logic [2:0] IDLE = 3'd0, SHIFT = 3'd1, HOLD = 3'd2, GAP = 3'd3, LATCH = 3'd4;

    logic [2:0]               state;
    logic [CHW-1:0]           ch;
    logic [BITW-1:0]          bidx;
    logic [CW-1:0]            cnt;
    logic                     hi;
    logic [WORD_W-1:0]        sh;
    logic [NUM_CH*DATA_W-1:0] data_q;
    logic [2:0]               rgb_q;
    logic [BW-1:0]            blank;
    logic [BW-1:0]            blank_nx;
    logic [WORD_W-1:0]        load_word;
    logic                     enter_latch;
    logic                     expire;

    function automatic logic [WORD_W-1:0] word_of(input logic [NUM_CH*DATA_W-1:0] d, input logic [CHW-1:0] c);
        return {4'(c), d[int'(c)*DATA_W +: DATA_W]};
    endfunction

    // Next SPI word: channel 0 of the incoming point from IDLE, otherwise the following captured channel
    always_comb begin
        load_word   = state == IDLE ? word_of(pt_data, '0) : word_of(data_q, ch + 1'b1);
        enter_latch = state == GAP && cnt == DIV_M1 && ch == LAST_CH;
        blank_nx    = blank == TMO ? blank : blank + 1'b1;
        expire      = WD_EN && blank_nx == TMO;
    end

    // Point sequencer: word shifting with SCLK phases, csn hold/gap, then the shared latch pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ch         <= '0;
            bidx       <= '0;
            cnt        <= '0;
            hi         <= 1'b0;
            sh         <= '0;
            data_q     <= '0;
            rgb_q      <= '0;
            pt_ready   <= 1'b1;
            busy       <= 1'b0;
            dac_sclk   <= 1'b0;
            dac_mosi   <= 1'b0;
            dac_csn    <= 1'b1;
            dac_latchn <= 1'b1;
        end else begin
            case (state)
                IDLE: if (pt_valid) begin
                    data_q   <= pt_data;
                    rgb_q    <= pt_rgb;
                    ch       <= '0;
                    state    <= SHIFT;
                    pt_ready <= 1'b0;
                    busy     <= 1'b1;
                    dac_csn  <= 1'b0;
                    sh       <= load_word;
                    dac_mosi <= load_word[WORD_W-1];
                    bidx     <= LAST_BIT;
                    cnt      <= '0;
                    hi       <= 1'b0;
                end
                SHIFT: begin
                    cnt <= cnt == DIV_M1 ? '0 : cnt + 1'b1;
                    if (cnt == DIV_M1) begin
                        hi       <= !hi;
                        dac_sclk <= !hi;
                        if (hi && bidx == '0) begin
                            state <= HOLD;
                        end else if (hi) begin
                            bidx     <= bidx - 1'b1;
                            sh       <= sh << 1;
                            dac_mosi <= sh[WORD_W-2];
                        end
                    end
                end
                HOLD: begin
                    cnt <= cnt == DIV_M1 ? '0 : cnt + 1'b1;
                    if (cnt == DIV_M1) begin
                        state   <= GAP;
                        dac_csn <= 1'b1;
                    end
                end
                GAP: begin
                    cnt <= cnt == DIV_M1 ? '0 : cnt + 1'b1;
                    if (cnt == DIV_M1 && ch != LAST_CH) begin
                        ch       <= ch + 1'b1;
                        state    <= SHIFT;
                        dac_csn  <= 1'b0;
                        sh       <= load_word;
                        dac_mosi <= load_word[WORD_W-1];
                        bidx     <= LAST_BIT;
                        hi       <= 1'b0;
                    end else if (cnt == DIV_M1) begin
                        state      <= LATCH;
                        dac_latchn <= 1'b0;
                    end
                end
                LATCH: begin
                    cnt <= cnt == LAT_M1 ? '0 : cnt + 1'b1;
                    if (cnt == LAT_M1) begin
                        state      <= IDLE;
                        dac_latchn <= 1'b1;
                        pt_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Laser colour applied at the latch edge; blanked once no latch has happened for BLANK_TIMEOUT cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank     <= '0;
            laser_rgb <= '0;
        end else begin
            blank     <= enter_latch ? '0 : blank_nx;
            laser_rgb <= enter_latch ? rgb_q : expire ? 3'b000 : laser_rgb;
        end
    end
endmodule

// File: tb/tb_galvo_dac_spi.sv
// tb_galvo_dac_spi: per-cycle model check of two configurations plus SPI decode and timing literals
module tb_galvo_dac_spi;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  valid = 2'b00;
    logic [23:0] data_a = '0;
    logic [63:0] data_b = '0;
    logic [2:0]  rgb_a = '0, rgb_b = '0;
    logic [1:0]  ready, busy, sclk, mosi, csn, latchn;
    logic [5:0]  laser;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int m_t[2] = '{0, 0};
    logic [19:0] mw[2][16];
    logic m_mosi[2] = '{1'b0, 1'b0};
    logic [2:0] m_crgb[2], m_lrgb[2];
    bit m_have[2] = '{1'b0, 1'b0};
    int m_lcyc[2] = '{0, 0};
    logic [8:0] ce, ca;

    int n_hs[2] = '{0, 0}, n_lat[2] = '{0, 0};
    int hs_hist[2][4];
    int lat_rel[2], lat_w[2], lat_cyc[2], rdy_rel[2], fall_rel[2];
    logic [2:0] lat_rgb[2];
    logic [19:0] sh_d[2] = '{20'h0, 20'h0};
    int nb[2] = '{0, 0}, rise[2] = '{0, 0}, n_rise[2] = '{0, 0}, bad_per[2] = '{0, 0};
    logic [19:0] dec[2][4];
    int decn[2][4];
    logic [1:0] p_latchn = 2'b11, p_ready = 2'b11, p_csn = 2'b11, p_sclk = 2'b00;
    logic [2:0] p_laser[2] = '{3'b0, 3'b0};
    int base, lat_before, base_r;

    galvo_dac_spi #(.NUM_CH(2), .DATA_W(12), .SCLK_DIV(2), .LATCH_W(2), .BLANK_TIMEOUT(50)) dut_a (
        .clk(clk), .reset(rst), .pt_data(data_a), .pt_rgb(rgb_a), .pt_valid(valid[0]), .pt_ready(ready[0]),
        .laser_rgb(laser[2:0]), .dac_sclk(sclk[0]), .dac_mosi(mosi[0]), .dac_csn(csn[0]),
        .dac_latchn(latchn[0]), .busy(busy[0]));

    galvo_dac_spi #(.NUM_CH(4), .DATA_W(16), .SCLK_DIV(1), .LATCH_W(2), .BLANK_TIMEOUT(0)) dut_b (
        .clk(clk), .reset(rst), .pt_data(data_b), .pt_rgb(rgb_b), .pt_valid(valid[1]), .pt_ready(ready[1]),
        .laser_rgb(laser[5:3]), .dac_sclk(sclk[1]), .dac_mosi(mosi[1]), .dac_csn(csn[1]),
        .dac_latchn(latchn[1]), .busy(busy[1]));

    always #5 clk = ~clk;

    function automatic int nch(input int i); return i != 0 ? 4 : 2; endfunction
    function automatic int ww(input int i); return i != 0 ? 20 : 16; endfunction
    function automatic int dv(input int i); return i != 0 ? 1 : 2; endfunction
    function automatic int tmo(input int i); return i != 0 ? 0 : 50; endfunction
    function automatic int total(input int i); return nch(i) * (2 * ww(i) + 2) * dv(i); endfunction

    // Expected {ready, busy, csn, sclk, mosi, latchn} from the cycle offset within the point
    function automatic logic [5:0] exp_spi(input int i);
        int w, d, p, u, c, r;
        w = ww(i);
        d = dv(i);
        p = (2 * w + 2) * d;
        if (m_t[i] == 0) return {4'b1010, m_mosi[i], 1'b1};
        if (m_t[i] <= total(i)) begin
            u = m_t[i] - 1;
            c = u / p;
            r = u % p;
            if (r < 2 * w * d) return {3'b010, (r % (2 * d)) >= d, mw[i][c][w - 1 - r / (2 * d)], 1'b1};
            return {2'b01, r >= (2 * w + 1) * d, 1'b0, mw[i][c][0], 1'b1};
        end
        return {4'b0110, mw[i][nch(i) - 1][0], 1'b0};
    endfunction

    function automatic logic [2:0] exp_laser(input int i);
        if (!m_have[i] || (tmo(i) != 0 && cyc - m_lcyc[i] >= tmo(i))) return 3'b000;
        return m_lrgb[i];
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: accept when idle, then advance one cycle per clock until the latch pulse completes
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i] = 0;
                m_mosi[i] = 1'b0;
                m_have[i] = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (m_t[i] == 0) begin
                    if (valid[i]) begin
                        for (int c = 0; c < nch(i); c++)
                            if (i != 0) mw[i][c] = {4'(c), data_b[16*c +: 16]};
                            else mw[i][c] = 20'({4'(c), data_a[12*c +: 12]});
                        m_crgb[i] = i != 0 ? rgb_b : rgb_a;
                        m_t[i] = 1;
                    end
                end else begin
                    m_t[i]++;
                    if (m_t[i] == total(i) + 1) begin
                        m_have[i] = 1'b1;
                        m_lcyc[i] = cyc;
                        m_lrgb[i] = m_crgb[i];
                    end
                    if (m_t[i] > total(i) + 2) begin
                        m_t[i] = 0;
                        m_mosi[i] = mw[i][nch(i) - 1][0];
                    end
                end
            end
        end
    end

    // Compare every output each cycle, then update decoder and timing monitors
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ce = {exp_spi(i), exp_laser(i)};
            ca = {ready[i], busy[i], csn[i], sclk[i], mosi[i], latchn[i], laser[3*i +: 3]};
            chk(i != 0 ? "cycle_b" : "cycle_a", int'(ca), int'(ce));
            if (valid[i] && ready[i]) begin
                n_hs[i]++;
                for (int k = 3; k > 0; k--) hs_hist[i][k] = hs_hist[i][k-1];
                hs_hist[i][0] = cyc;
            end
            if (!latchn[i] && p_latchn[i]) begin
                n_lat[i]++;
                lat_rel[i] = cyc - hs_hist[i][0];
                lat_cyc[i] = cyc;
                lat_rgb[i] = laser[3*i +: 3];
                lat_w[i] = 0;
            end
            if (!latchn[i]) lat_w[i]++;
            if (ready[i] && !p_ready[i]) rdy_rel[i] = cyc - hs_hist[i][0];
            if (laser[3*i +: 3] == 3'b000 && p_laser[i] != 3'b000) fall_rel[i] = cyc - lat_cyc[i];
            if (sclk[i] && !p_sclk[i] && !csn[i]) begin
                sh_d[i] = {sh_d[i][18:0], mosi[i]};
                nb[i]++;
                if (nb[i] > 1 && cyc - rise[i] != 2 * dv(i)) bad_per[i]++;
                rise[i] = cyc;
                n_rise[i]++;
            end
            if (csn[i] && !p_csn[i]) begin
                for (int k = 3; k > 0; k--) begin
                    dec[i][k] = dec[i][k-1];
                    decn[i][k] = decn[i][k-1];
                end
                dec[i][0] = sh_d[i];
                decn[i][0] = nb[i];
                sh_d[i] = '0;
                nb[i] = 0;
            end
            p_laser[i] = laser[3*i +: 3];
        end
        p_latchn = latchn;
        p_ready = ready;
        p_csn = csn;
        p_sclk = sclk;
    end

    initial begin
        tick(3);
        rst = 1'b0;
        tick(60);
        chk("idle_laser", int'(laser), 0);
        chk("idle_ready", int'(ready), 3);
        chk("idle_csn", int'(csn), 3);
        chk("idle_latchn", int'(latchn), 3);

        data_a = 24'hABC123;
        rgb_a = 3'b101;
        valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        data_a = '0;
        rgb_a = '0;
        tick(150);
        chk("single_latch_at", lat_rel[0], 137);
        chk("single_latch_width", lat_w[0], 2);
        chk("single_laser", int'(lat_rgb[0]), 5);
        chk("single_ready_at", rdy_rel[0], 139);
        chk("word0", int'(dec[0][1]), 'h0123);
        chk("word0_edges", decn[0][1], 16);
        chk("word1", int'(dec[0][0]), 'h1ABC);
        chk("word1_edges", decn[0][0], 16);
        tick(60);
        chk("blank_after", fall_rel[0], 50);

        data_a = 24'h000FFF;
        rgb_a = 3'b111;
        valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        tick(150);
        chk("wd_laser_restored", int'(laser[2:0]), 7);
        tick(60);
        chk("wd_blank_after", fall_rel[0], 50);
        chk("wd_laser_off", int'(laser[2:0]), 0);

        base = n_hs[0];
        rgb_a = 3'b110;
        valid[0] = 1'b1;
        for (int k = 0; k < 600; k++) begin
            tick(1);
            if (n_hs[0] >= base + 3) break;
            data_a = 24'($urandom);
        end
        valid[0] = 1'b0;
        chk("b2b_count", n_hs[0] - base, 3);
        chk("b2b_period1", hs_hist[0][1] - hs_hist[0][2], 139);
        chk("b2b_period2", hs_hist[0][0] - hs_hist[0][1], 139);
        tick(200);
        chk("b2b_no_extra", n_hs[0] - base, 3);
        chk("b2b_colour", int'(lat_rgb[0]), 6);

        lat_before = n_lat[0];
        data_a = 24'h5A53C3;
        rgb_a = 3'b011;
        valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        tick(80);
        rst = 1'b1;
        tick(1);
        chk("rst_csn", int'(csn[0]), 1);
        chk("rst_laser", int'(laser[2:0]), 0);
        chk("rst_ready", int'(ready[0]), 1);
        tick(2);
        rst = 1'b0;
        tick(150);
        chk("rst_no_latch", n_lat[0], lat_before);
        data_a = 24'h876543;
        rgb_a = 3'b100;
        valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        tick(150);
        chk("post_rst_latches", n_lat[0], lat_before + 1);
        chk("post_rst_latch_at", lat_rel[0], 137);
        chk("post_rst_word0", int'(dec[0][1]), 'h0543);
        chk("post_rst_word1", int'(dec[0][0]), 'h1876);
        chk("sclk_period_a", bad_per[0], 0);

        base_r = n_rise[1];
        data_b = 64'hFEDC_BA98_7654_3210;
        rgb_b = 3'b011;
        valid[1] = 1'b1;
        tick(1);
        valid[1] = 1'b0;
        data_b = '0;
        tick(180);
        chk("b_latch_at", lat_rel[1], 169);
        chk("b_latch_width", lat_w[1], 2);
        chk("b_laser", int'(lat_rgb[1]), 3);
        chk("b_ready_at", rdy_rel[1], 171);
        chk("b_word0", int'(dec[1][3]), 'h03210);
        chk("b_word1", int'(dec[1][2]), 'h17654);
        chk("b_word2", int'(dec[1][1]), 'h2BA98);
        chk("b_word3", int'(dec[1][0]), 'h3FEDC);
        chk("b_word_edges", decn[1][0], 20);
        chk("b_rises", n_rise[1] - base_r, 80);
        chk("b_sclk_period", bad_per[1], 0);
        tick(300);
        chk("b_no_blank", int'(laser[5:3]), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
